rx_cmd_ctrl: RTL and testbench
==============================

Name: rx_cmd_ctrl

Overview:
Packet-level controller that sits directly downstream of the UART receiver.
- Sequences the received byte stream into 4-byte write commands: SOF, ADDR, DATA, CSUM.
- Checks framing, checksum and inter-byte timeout.
- Issues a single-cycle register-write strobe to the local register file on each valid packet.
- Maintains sticky error flags and a packet counter for the host.

Parameters:
- SOF, 8'hA5, start-of-frame byte value.
- TO_W, 17, width of the inter-byte timeout counter.
- TO_CNT, 17'd104160, timeout in clk cycles: two byte times at 5208 clk/bit × 10 bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  block enable; 0 forces IDLE and ignores bytes.
- rx_valid  input  1  one-cycle strobe, rx_byte valid this cycle.
- rx_byte  input  8  received byte from UART receiver.
- clr_err  input  1  one-cycle pulse, clears sticky error flags.
- wr_en  output  1  one-cycle register write strobe.
- wr_addr  output  8  register address, valid when wr_en=1.
- wr_data  output  8  register data, valid when wr_en=1.
- busy  output  1  1 whenever state is not IDLE.
- err_csum  output  1  sticky checksum-mismatch flag.
- err_to  output  1  sticky inter-byte timeout flag.
- pkt_cnt  output  8  count of accepted packets, wraps 8'hFF→8'h00.

Behaviour:
- Reset (n_rst=0, asynchronous) sets:
  - state=IDLE, timeout counter=0, addr/data holding regs=0.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, err_csum=0, err_to=0, pkt_cnt=0.
- Reset mid-packet discards the partial packet; no write is issued.
- All outputs are registered.
- States: IDLE, ADDR, DATA, CSUM.
- Transitions, evaluated on each cycle with rx_valid=1:
  - IDLE: rx_byte==SOF → ADDR. Any other byte is ignored and state stays IDLE.
  - ADDR: latch rx_byte into addr reg → DATA.
  - DATA: latch rx_byte into data reg → CSUM.
  - CSUM: → IDLE in all cases.
    - If rx_byte == (addr + data) mod 256, the packet is accepted.
    - Otherwise err_csum is set to 1 and no write is issued.
- An SOF value received in ADDR, DATA or CSUM is treated as ordinary data; there is no resync.
- Write latency:
  - wr_en=1 is asserted in the cycle after the accepting CSUM byte is sampled.
  - It lasts exactly 1 cycle.
  - wr_addr and wr_data are updated in that same cycle and hold their values afterwards.
  - pkt_cnt increments in the same cycle as wr_en.
- busy = (state != IDLE), registered with the state.
- Timeout:
  - The counter is cleared in IDLE and on every rx_valid.
  - Otherwise it increments each clk while in ADDR, DATA or CSUM.
  - When the counter equals TO_CNT-1 and rx_valid=0, next state is IDLE, err_to is set to 1, the counter clears, and no write is issued.
  - If rx_valid=1 in the same cycle that the counter reaches TO_CNT-1, the byte wins: normal transition, no timeout.
- en=0:
  - Next state is IDLE from any state and the counter clears; rx_valid is ignored.
  - No error flag is set.
  - Error flags and pkt_cnt are held.
- Error flags are sticky until clr_err=1. If clr_err and a new error event occur in the same cycle, the flag reads 1 afterward (set wins).
- The counter does not saturate; the pkt_cnt wrap is silent.
- Back-to-back packets: an SOF arriving in the cycle after CSUM (in IDLE, while wr_en=1) is accepted normally.

Test Plan:
- Bytes A5,10,22,32 with 5208×10 cycle gaps → exactly one wr_en pulse with wr_addr=10, wr_data=22, one cycle after the CSUM strobe; pkt_cnt=1; err flags 0.
- Bytes A5,10,22,33 → no wr_en; err_csum=1; state IDLE. Then a clr_err pulse → err_csum=0.
- Bytes 00,FF,A5,F0,20,10 → the leading 00,FF are ignored; write addr=F0, data=20 (checksum wraps: F0+20=110 → 10).
- Bytes A5,01 then silence for 104160 cycles → err_to=1, busy=0 after exactly TO_CNT cycles from the 01 strobe, no wr_en. A byte arriving at count TO_CNT-1 → no timeout.
- Drive en=0 mid-packet after A5,05, then en=1 and send 07,0C → no write; the 07 and 0C are ignored in IDLE.
- n_rst pulsed low after A5,05,06 → all outputs 0 immediately. The following byte 0B produces no write; 256 good packets → pkt_cnt returns to 00.

Source files
------------

// File: rtl/rx_cmd_ctrl_if.sv
// rx_cmd_ctrl_if: groups the signals that run between the command controller
// and its environment.
//   Host/UART side (driven into the controller):
//     en        - block enable; 0 forces the controller back to IDLE
//     rx_valid  - one-cycle strobe, rx_byte is valid this cycle
//     rx_byte   - received byte from the UART receiver
//     clr_err   - one-cycle pulse that clears the sticky error flags
//   Register-file/host side (driven by the controller, all registered):
//     wr_en     - one-cycle register write strobe
//     wr_addr   - write address, valid while wr_en=1 and held afterwards
//     wr_data   - write data, valid while wr_en=1 and held afterwards
//     busy      - 1 whenever a packet is in progress
//     err_csum  - sticky checksum-mismatch flag
//     err_to    - sticky inter-byte timeout flag
//     pkt_cnt   - count of accepted packets, wraps silently
// Handshake: rx_valid is a pure strobe with no ready/backpressure. A byte is
// consumed on every rising clk edge where rx_valid=1 and en=1; the sender
// never waits. wr_en is likewise a one-cycle strobe the register file must
// accept unconditionally.
interface rx_cmd_ctrl_if;
  logic       en;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       clr_err;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err_csum;
  logic       err_to;
  logic [7:0] pkt_cnt;

  // Environment side: drives controls and the byte stream, observes results.
  modport master (
    output en, rx_valid, rx_byte, clr_err,
    input  wr_en, wr_addr, wr_data, busy, err_csum, err_to, pkt_cnt
  );

  // Controller side.
  modport slave (
    input  en, rx_valid, rx_byte, clr_err,
    output wr_en, wr_addr, wr_data, busy, err_csum, err_to, pkt_cnt
  );
endinterface

// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: packet-level controller behind the UART receiver.
// Assembles 4-byte write commands (SOF, ADDR, DATA, CSUM), checks the
// checksum (ADDR+DATA mod 256) and the inter-byte timeout, issues a
// single-cycle register write on each good packet, and keeps sticky error
// flags plus an accepted-packet counter.
// Ports:
//   clk     - system clock, rising edge
//   n_rst   - asynchronous active-low reset
//   bus     - rx_cmd_ctrl_if slave modport (byte stream in, write/status out)
//   state_o - current FSM state, for debug/observation
module rx_cmd_ctrl #(
  parameter logic [7:0]      SOF    = 8'hA5,
  parameter int unsigned     TO_W   = 17,
  parameter logic [TO_W-1:0] TO_CNT = 17'd104160
) (
  input  logic          clk,
  input  logic          n_rst,
  rx_cmd_ctrl_if.slave  bus,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CNT - 1'b1;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            busy_q;
  logic            err_csum_q, err_csum_d;
  logic            err_to_q, err_to_d;
  logic [7:0]      pkt_cnt_q, pkt_cnt_d;

  logic [7:0]      sum;
  logic            csum_bad;
  logic            to_hit;

  assign sum = addr_q + data_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      to_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_csum_q <= 1'b0;
      err_to_q   <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= (state_d != IDLE);
      err_csum_q <= err_csum_d;
      err_to_q   <= err_to_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pkt_cnt_d = pkt_cnt_q;
    csum_bad  = 1'b0;
    to_hit    = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      to_d    = '0;
    end else if (bus.rx_valid) begin
      // A byte always restarts the gap timer, even on the cycle the timer
      // would otherwise expire: the byte wins.
      to_d = '0;
      unique case (state_q)
        IDLE: if (bus.rx_byte == SOF) state_d = ADDR;
        ADDR: begin
          addr_d  = bus.rx_byte;
          state_d = DATA;
        end
        DATA: begin
          data_d  = bus.rx_byte;
          state_d = CSUM;
        end
        CSUM: begin
          state_d = IDLE;
          if (bus.rx_byte == sum) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
            pkt_cnt_d = pkt_cnt_q + 8'd1;
          end else begin
            csum_bad = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TO_LAST) begin
        to_hit  = 1'b1;
        state_d = IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end

    // Set has priority over a simultaneous clear.
    err_csum_d = (err_csum_q & ~bus.clr_err) | csum_bad;
    err_to_d   = (err_to_q   & ~bus.clr_err) | to_hit;
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.err_csum = err_csum_q;
  assign bus.err_to   = err_to_q;
  assign bus.pkt_cnt  = pkt_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb_rx_cmd_ctrl: directed, table-driven bench for rx_cmd_ctrl.
// The timeout is shortened so the bench stays short; byte gaps are a few
// clocks instead of a full UART byte time.
module tb_rx_cmd_ctrl;
  localparam logic [16:0] TO_CNT_TB = 17'd40;

  logic       clk;
  logic       n_rst;
  logic [1:0] state_dbg;

  rx_cmd_ctrl_if bus ();

  rx_cmd_ctrl #(
    .SOF    (8'hA5),
    .TO_W   (17),
    .TO_CNT (TO_CNT_TB)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] b;
    logic       clr;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_csum;
    logic       e_to;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge, then one edge passes,
  // and the caller samples 1 time unit after that edge.
  task automatic drive(input logic en, input logic v, input logic [7:0] b, input logic clr);
    bus.en       = en;
    bus.rx_valid = v;
    bus.rx_byte  = b;
    bus.clr_err  = clr;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic vec_t mk(input logic en, input logic v, input logic [7:0] b,
                              input logic clr, input logic e_wr, input logic [7:0] e_addr,
                              input logic [7:0] e_data, input logic e_busy,
                              input logic e_csum, input logic e_to, input logic [7:0] e_cnt);
    vec_t r;
    r.en = en; r.v = v; r.b = b; r.clr = clr; r.e_wr = e_wr; r.e_addr = e_addr;
    r.e_data = e_data; r.e_busy = e_busy; r.e_csum = e_csum; r.e_to = e_to; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    int first_idle;
    int wr_seen;
    logic [7:0] a, d;

    bus.en = 1'b1; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.clr_err = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // ---------------- reset state ----------------
    check("rst_wr_en",   {7'd0, bus.wr_en}, 8'h00);
    check("rst_wr_addr", bus.wr_addr, 8'h00);
    check("rst_wr_data", bus.wr_data, 8'h00);
    check("rst_busy",    {7'd0, bus.busy}, 8'h00);
    check("rst_err_csum",{7'd0, bus.err_csum}, 8'h00);
    check("rst_err_to",  {7'd0, bus.err_to}, 8'h00);
    check("rst_pkt_cnt", bus.pkt_cnt, 8'h00);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- vector table ----------------
    // good packet with gaps: A5,10,22,32
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h00,8'h00,1,0,0,8'd0));
    vecs.push_back(mk(1,0,8'h00,0, 0,8'h00,8'h00,1,0,0,8'd0));
    vecs.push_back(mk(1,1,8'h10,0, 0,8'h00,8'h00,1,0,0,8'd0));
    vecs.push_back(mk(1,1,8'h22,0, 0,8'h00,8'h00,1,0,0,8'd0));
    vecs.push_back(mk(1,0,8'h00,0, 0,8'h00,8'h00,1,0,0,8'd0));
    vecs.push_back(mk(1,1,8'h32,0, 1,8'h10,8'h22,0,0,0,8'd1));
    vecs.push_back(mk(1,0,8'h00,0, 0,8'h10,8'h22,0,0,0,8'd1));
    // bad checksum A5,10,22,33 then clr_err
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'h10,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'h22,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'h33,0, 0,8'h10,8'h22,0,1,0,8'd1));
    vecs.push_back(mk(1,0,8'h00,1, 0,8'h10,8'h22,0,0,0,8'd1));
    // leading junk, checksum wrap: 00,FF,A5,F0,20,10
    vecs.push_back(mk(1,1,8'h00,0, 0,8'h10,8'h22,0,0,0,8'd1));
    vecs.push_back(mk(1,1,8'hFF,0, 0,8'h10,8'h22,0,0,0,8'd1));
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'hF0,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'h20,0, 0,8'h10,8'h22,1,0,0,8'd1));
    vecs.push_back(mk(1,1,8'h10,0, 1,8'hF0,8'h20,0,0,0,8'd2));
    // back-to-back: SOF in the wr_en cycle is accepted
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'hF0,8'h20,1,0,0,8'd2));
    vecs.push_back(mk(1,1,8'h01,0, 0,8'hF0,8'h20,1,0,0,8'd2));
    vecs.push_back(mk(1,1,8'h02,0, 0,8'hF0,8'h20,1,0,0,8'd2));
    vecs.push_back(mk(1,1,8'h03,0, 1,8'h01,8'h02,0,0,0,8'd3));
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h01,8'h02,1,0,0,8'd3));
    // en=0 mid-packet, then 07,0C ignored in IDLE
    vecs.push_back(mk(1,1,8'h05,0, 0,8'h01,8'h02,1,0,0,8'd3));
    vecs.push_back(mk(0,0,8'h00,0, 0,8'h01,8'h02,0,0,0,8'd3));
    vecs.push_back(mk(1,1,8'h07,0, 0,8'h01,8'h02,0,0,0,8'd3));
    vecs.push_back(mk(1,1,8'h0C,0, 0,8'h01,8'h02,0,0,0,8'd3));
    // en=0 with a byte present: byte ignored, state forced IDLE
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h01,8'h02,1,0,0,8'd3));
    vecs.push_back(mk(0,1,8'h05,0, 0,8'h01,8'h02,0,0,0,8'd3));
    vecs.push_back(mk(1,0,8'h00,0, 0,8'h01,8'h02,0,0,0,8'd3));
    // checksum error coinciding with clr_err: set wins, next clr clears
    vecs.push_back(mk(1,1,8'hA5,0, 0,8'h01,8'h02,1,0,0,8'd3));
    vecs.push_back(mk(1,1,8'h00,0, 0,8'h01,8'h02,1,0,0,8'd3));
    vecs.push_back(mk(1,1,8'h00,0, 0,8'h01,8'h02,1,0,0,8'd3));
    vecs.push_back(mk(1,1,8'h01,1, 0,8'h01,8'h02,0,1,0,8'd3));
    vecs.push_back(mk(1,0,8'h00,1, 0,8'h01,8'h02,0,0,0,8'd3));

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].v, vecs[i].b, vecs[i].clr);
      check($sformatf("v%0d_wr_en", i),    {7'd0, bus.wr_en},    {7'd0, vecs[i].e_wr});
      check($sformatf("v%0d_wr_addr", i),  bus.wr_addr,          vecs[i].e_addr);
      check($sformatf("v%0d_wr_data", i),  bus.wr_data,          vecs[i].e_data);
      check($sformatf("v%0d_busy", i),     {7'd0, bus.busy},     {7'd0, vecs[i].e_busy});
      check($sformatf("v%0d_err_csum", i), {7'd0, bus.err_csum}, {7'd0, vecs[i].e_csum});
      check($sformatf("v%0d_err_to", i),   {7'd0, bus.err_to},   {7'd0, vecs[i].e_to});
      check($sformatf("v%0d_pkt_cnt", i),  bus.pkt_cnt,          vecs[i].e_cnt);
    end

    // ---------------- timeout: silence after A5,01 ----------------
    send(8'hA5);
    send(8'h01);
    first_idle = 0;
    wr_seen = 0;
    for (int i = 1; i <= int'(TO_CNT_TB) + 5; i++) begin
      idle();
      if (bus.wr_en) wr_seen++;
      if (first_idle == 0 && !bus.busy) begin
        first_idle = i;
        check("to_err_to_set", {7'd0, bus.err_to}, 8'h01);
      end
    end
    check("to_latency", first_idle[7:0], TO_CNT_TB[7:0]);
    check("to_no_write", wr_seen[7:0], 8'h00);
    check("to_pkt_cnt", bus.pkt_cnt, 8'd3);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("to_clr", {7'd0, bus.err_to}, 8'h00);

    // ---------------- byte arriving at count TO_CNT-1 wins ----------------
    send(8'hA5);
    send(8'h01);
    for (int i = 1; i < int'(TO_CNT_TB); i++) idle();
    check("edge_busy_before", {7'd0, bus.busy}, 8'h01);
    send(8'h02);
    check("edge_busy_after", {7'd0, bus.busy}, 8'h01);
    check("edge_no_to", {7'd0, bus.err_to}, 8'h00);
    send(8'h03);
    check("edge_wr_en", {7'd0, bus.wr_en}, 8'h01);
    check("edge_wr_addr", bus.wr_addr, 8'h01);
    check("edge_wr_data", bus.wr_data, 8'h02);
    check("edge_pkt_cnt", bus.pkt_cnt, 8'd4);

    // ---------------- async reset mid-packet ----------------
    send(8'hA5); send(8'h00); send(8'h00); send(8'h07);
    check("pre_rst_err_csum", {7'd0, bus.err_csum}, 8'h01);
    send(8'hA5); send(8'h05); send(8'h06);
    check("pre_rst_busy", {7'd0, bus.busy}, 8'h01);
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy",     {7'd0, bus.busy}, 8'h00);
    check("arst_err_csum", {7'd0, bus.err_csum}, 8'h00);
    check("arst_pkt_cnt",  bus.pkt_cnt, 8'h00);
    check("arst_wr_addr",  bus.wr_addr, 8'h00);
    check("arst_wr_data",  bus.wr_data, 8'h00);
    @(posedge clk); #1;
    n_rst = 1'b1;
    send(8'h0B);
    check("post_rst_wr_en", {7'd0, bus.wr_en}, 8'h00);
    check("post_rst_busy",  {7'd0, bus.busy}, 8'h00);
    check("post_rst_cnt",   bus.pkt_cnt, 8'h00);

    // ---------------- 256 good packets: pkt_cnt wraps ----------------
    wr_seen = 0;
    for (int p = 0; p < 256; p++) begin
      a = 8'(p);
      d = 8'(p * 3 + 1);
      send(8'hA5); send(a); send(d); send(a + d);
      if (bus.wr_en && bus.wr_addr == a && bus.wr_data == d) wr_seen++;
      if (p == 0) check("wrap_first_cnt", bus.pkt_cnt, 8'd1);
      if (p == 254) check("wrap_ff_cnt", bus.pkt_cnt, 8'hFF);
    end
    check("wrap_writes", (wr_seen == 256) ? 8'h01 : 8'h00, 8'h01);
    check("wrap_cnt", bus.pkt_cnt, 8'h00);
    check("wrap_err_csum", {7'd0, bus.err_csum}, 8'h00);
    idle();
    check("wrap_wr_en_drop", {7'd0, bus.wr_en}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus process stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
